// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter in front of a 1K-word data memory
// Each access takes IDLE -> ACCESS -> ACK; bad addresses are answered with Err instead of touching memory.
module data_mem_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Wr0,
  input  logic        Wr1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WData0,
  input  logic [31:0] WData1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Err0,
  output logic        Err1,
  output logic [31:0] RData0,
  output logic [31:0] RData1,
  output logic        Busy,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_grant;
  logic        r_last_grant;
  logic        w_win;
  logic        w_wr;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_valid;
  logic        w_access;
  logic        w_start;

  always_comb begin
    w_wr    = r_grant ? Wr1 : Wr0;
    w_addr  = r_grant ? Addr1 : Addr0;
    w_wdata = r_grant ? WData1 : WData0;
    w_valid = (w_addr[1:0] == 2'b00) && (w_addr[31:12] == 20'd0);
    // On a tie the port that did not win last time gets the grant.
    w_win   = (Req0 && Req1) ? ~r_last_grant : Req1;
    w_next  = r_state;
    case (r_state)
      IDLE:    if (Req0 || Req1) w_next = ACCESS;
      ACCESS:  w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_access = (r_state == ACCESS);
  assign w_start  = (r_state == IDLE) && (Req0 || Req1);

  // Strobes are gated by Reset so an access interrupted by reset never commits.
  always_comb begin
    MemAddress   = 32'd0;
    MemWriteData = 32'd0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    if (w_access) begin
      MemAddress   = w_addr;
      MemWriteData = w_wdata;
      MemWrite     = Reset && w_valid && w_wr;
      MemRead      = Reset && w_valid && !w_wr;
    end
  end

  assign Busy = (r_state != IDLE);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      Ack0         <= 1'b0;
      Ack1         <= 1'b0;
      Err0         <= 1'b0;
      Err1         <= 1'b0;
      RData0       <= 32'd0;
      RData1       <= 32'd0;
    end else begin
      r_state <= w_next;
      Ack0    <= 1'b0;
      Ack1    <= 1'b0;
      Err0    <= 1'b0;
      Err1    <= 1'b0;
      if (w_start) begin
        r_grant      <= w_win;
        r_last_grant <= w_win;
      end
      if (w_access) begin
        if (r_grant) begin
          Ack1 <= 1'b1;
          Err1 <= ~w_valid;
          if (w_valid && !w_wr) RData1 <= MemReadData;
        end else begin
          Ack0 <= 1'b1;
          Err0 <= ~w_valid;
          if (w_valid && !w_wr) RData0 <= MemReadData;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
// Transaction-timed reference model plus directed scenarios and randomized two-port traffic.
module tb_data_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req0, Req1, Wr0, Wr1;
  logic [31:0] Addr0, Addr1, WData0, WData1;
  logic        Ack0, Ack1, Err0, Err1, Busy, MemWrite, MemRead;
  logic [31:0] RData0, RData1, MemAddress, MemWriteData, MemReadData;

  data_mem_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
    .RData0(RData0), .RData1(RData1), .Busy(Busy),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;

  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  assign MemReadData = env_mem[MemAddress[11:2]];
  always @(posedge Clk) if (MemWrite) env_mem[MemAddress[11:2]] <= MemWriteData;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a grant at cycle g means access in g+1 and Ack in g+2.
  int          cyc = 0;
  int          g_cyc = -100;
  int          last_win = 1;
  int          t_port = 0;
  logic        t_wr = 1'b0;
  logic        t_valid = 1'b0;
  logic [31:0] t_addr = 32'd0;
  logic [31:0] t_wdata = 32'd0;
  logic [31:0] exp_rd [2];
  bit          armed = 0;
  bit          saw_mem_op = 0;
  bit          saw_ack1 = 0;
  int          ack0_cnt = 0;

  always @(negedge Clk) begin
    int ph;
    ph = (cyc == g_cyc + 1) ? 1 : ((cyc == g_cyc + 2) ? 2 : 0);
    if (armed) begin
      chk("busy", 32'(Busy), 32'(ph != 0));
      chk("mem_read", 32'(MemRead), 32'(ph == 1 && t_valid && !t_wr && Reset));
      chk("mem_write", 32'(MemWrite), 32'(ph == 1 && t_valid && t_wr && Reset));
      if (ph != 1) begin
        chk("mem_addr_idle", MemAddress, 32'd0);
        chk("mem_wdata_idle", MemWriteData, 32'd0);
      end else if (t_valid) begin
        chk("mem_addr", MemAddress, t_addr);
        if (t_wr) chk("mem_wdata", MemWriteData, t_wdata);
      end
      chk("ack0", 32'(Ack0), 32'(ph == 2 && t_port == 0));
      chk("ack1", 32'(Ack1), 32'(ph == 2 && t_port == 1));
      chk("err0", 32'(Err0), 32'(ph == 2 && t_port == 0 && !t_valid));
      chk("err1", 32'(Err1), 32'(ph == 2 && t_port == 1 && !t_valid));
      chk("rdata0", RData0, exp_rd[0]);
      chk("rdata1", RData1, exp_rd[1]);
    end
    if (MemRead || MemWrite) saw_mem_op = 1;
    if (Ack1) saw_ack1 = 1;
    if (Ack0) ack0_cnt++;
    if (!Reset) begin
      armed     = 1;
      g_cyc     = -100;
      last_win  = 1;
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
    end else if (ph == 1) begin
      if (t_valid) begin
        if (t_wr) ref_mem[t_addr[11:2]] = t_wdata;
        else exp_rd[t_port] = ref_mem[t_addr[11:2]];
      end
    end else if (ph == 0 && (Req0 || Req1)) begin
      t_port   = (Req0 && Req1) ? 1 - last_win : (Req1 ? 1 : 0);
      last_win = t_port;
      t_wr     = (t_port == 1) ? Wr1 : Wr0;
      t_addr   = (t_port == 1) ? Addr1 : Addr0;
      t_wdata  = (t_port == 1) ? WData1 : WData0;
      t_valid  = (t_addr[1:0] == 2'b00) && (t_addr[31:12] == 20'd0);
      g_cyc    = cyc;
    end
    cyc++;
  end

  task automatic do_req(input int p, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int n, output logic e);
    bit got;
    if (p == 0) begin Wr0 = wr; Addr0 = a; WData0 = d; Req0 = 1'b1; end
    else        begin Wr1 = wr; Addr1 = a; WData1 = d; Req1 = 1'b1; end
    n = 0; got = 0; e = 1'b0;
    while (!got && n < 12) begin
      @(posedge Clk); #1;
      n++;
      if ((p == 0) ? Ack0 : Ack1) begin
        got = 1;
        e = (p == 0) ? Err0 : Err1;
      end
    end
    if (p == 0) Req0 = 1'b0; else Req1 = 1'b0;
    chk("ack_timeout", 32'(got), 32'd1);
    @(posedge Clk); #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
  endtask

  task automatic rand_port(input int p);
    int          r;
    int          n;
    logic        e;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 4) == 0) ? 32'd256 : 32'($urandom_range(0, 15)) << 2;
      if (r == 8) a = a | 32'($urandom_range(1, 3));
      if (r == 9) a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      do_req(p, 1'($urandom_range(0, 1)), a, $urandom, n, e);
    end
  endtask

  initial begin
    int          n;
    logic        e;
    int          k;
    int          ports [4];
    int          at [4];

    for (int i = 0; i < 1024; i++) begin env_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    env_mem[0] = 32'h30E; env_mem[64] = 32'h40;
    ref_mem[0] = 32'h30E; ref_mem[64] = 32'h40;
    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0; Wr0 = 1'b0; Wr1 = 1'b0;
    Addr0 = 32'd0; Addr1 = 32'd0; WData0 = 32'd0; WData1 = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_rdata0", RData0, 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    Reset = 1'b1;

    do_req(0, 1'b0, 32'h0, 32'h0, n, e);
    chk("t1_latency", 32'(n), 32'd2);
    chk("t1_rdata0", RData0, 32'h30E);
    chk("t1_err0", 32'(e), 32'd0);

    do_req(1, 1'b1, 32'h100, 32'hDEADBEEF, n, e);
    chk("t2_write_err1", 32'(e), 32'd0);
    do_req(0, 1'b0, 32'h100, 32'h0, n, e);
    chk("t2_rdata0", RData0, 32'hDEADBEEF);

    apply_reset();
    Wr0 = 1'b0; Addr0 = 32'h0; Wr1 = 1'b0; Addr1 = 32'h100;
    Req0 = 1'b1; Req1 = 1'b1;
    k = 0;
    for (int c = 1; c <= 20 && k < 4; c++) begin
      @(posedge Clk); #1;
      if (Ack0) begin ports[k] = 0; at[k] = c; k++; end
      else if (Ack1) begin ports[k] = 1; at[k] = c; k++; end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    chk("t3_ack_count", 32'(k), 32'd4);
    if (k > 0) chk("t3_first_ack_cycle", 32'(at[0]), 32'd2);
    for (int i = 0; i < k; i++) begin
      chk("t3_ack_port", 32'(ports[i]), 32'(i % 2));
      if (i > 0) chk("t3_ack_spacing", 32'(at[i] - at[i-1]), 32'd3);
    end
    @(posedge Clk); #1;
    chk("t3_rdata1", RData1, 32'hDEADBEEF);

    saw_mem_op = 0;
    do_req(0, 1'b0, 32'h102, 32'h0, n, e);
    chk("t4_unaligned_err0", 32'(e), 32'd1);
    chk("t4_unaligned_rdata0", RData0, 32'h30E);
    do_req(0, 1'b0, 32'h1000, 32'h0, n, e);
    chk("t4_range_err0", 32'(e), 32'd1);
    chk("t4_range_rdata0", RData0, 32'h30E);
    chk("t4_no_mem_op", 32'(saw_mem_op), 32'd0);

    Wr1 = 1'b1; Addr1 = 32'h0; WData1 = 32'h12345678; Req1 = 1'b1;
    @(posedge Clk); #1;
    saw_ack1 = 0;
    Reset = 1'b0; Req1 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    chk("t5_no_ack1", 32'(saw_ack1), 32'd0);
    do_req(0, 1'b0, 32'h0, 32'h0, n, e);
    chk("t5_mem_intact", RData0, 32'h30E);

    ack0_cnt = 0;
    Wr0 = 1'b0; Addr0 = 32'h100; Req0 = 1'b1;
    @(posedge Clk); #1;
    Req0 = 1'b0;
    @(posedge Clk); #1;
    chk("t6_ack0_pulse", 32'(Ack0), 32'd1);
    @(posedge Clk); #1;
    chk("t6_busy_low", 32'(Busy), 32'd0);
    @(posedge Clk); #1;
    chk("t6_ack0_once", 32'(ack0_cnt), 32'd1);

    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (3) @(posedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
